// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
// Module      : div_pkg
// Description : Shared width default and FSM state encoding for the
//               repeated-subtraction divider.
// Revision    : 1.0 - initial release
// ============================================================================
package div_pkg;

    localparam int c_width_default = 16;

    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_loadd = 3'd1;
    localparam logic [2:0] c_st_check = 3'd2;
    localparam logic [2:0] c_st_iter  = 3'd3;
    localparam logic [2:0] c_st_done  = 3'd4;

endpackage : div_pkg
`default_nettype wire

// File: rtl/div_datapath.sv
`default_nettype none
// ============================================================================
// Module      : div_datapath
// Description : Remainder/divisor/quotient registers with subtractor,
//               comparator and zero detect for the repeated-subtraction divider.
// Revision    : 1.0 - initial release
// ============================================================================
module div_datapath
    import div_pkg::*;
#(
    parameter int WIDTH = c_width_default
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_ld_r,
    input  logic             i_sel_sub,
    input  logic             i_ld_d,
    input  logic             i_clr_q,
    input  logic             i_inc_q,
    output logic             o_ge,
    output logic             o_dz,
    output logic [WIDTH-1:0] o_r,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_r;
    logic [WIDTH-1:0] r_d;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_diff;

    // Only taken when R >= D, so the borrow is never needed.
    assign w_diff = r_r - r_d;
    assign o_ge   = (r_r >= r_d);
    assign o_dz   = (r_d == '0);
    assign o_r    = r_r;
    assign o_q    = r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_r <= '0;
            r_d <= '0;
            r_q <= '0;
        end else begin
            if (i_ld_r) begin
                r_r <= i_sel_sub ? w_diff : i_data;
            end
            if (i_ld_d) begin
                r_d <= i_data;
            end
            if (i_clr_q) begin
                r_q <= '0;
            end else if (i_inc_q) begin
                r_q <= r_q + WIDTH'(1);
            end
        end
    end

endmodule : div_datapath
`default_nettype wire

// File: rtl/div_repeated_sub.sv
`default_nettype none
// ============================================================================
// Module      : div_repeated_sub
// Description : Sequential unsigned divider by repeated subtraction; operands
//               loaded over one shared bus, result flagged by a done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module div_repeated_sub
    import div_pkg::*;
#(
    parameter int WIDTH = c_width_default
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    logic [2:0] r_state;
    logic [2:0] w_next;
    logic       r_dz;
    logic       w_ld_r;
    logic       w_sel_sub;
    logic       w_ld_d;
    logic       w_clr_q;
    logic       w_inc_q;
    logic       w_ge;
    logic       w_dz;

    div_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .clk       (clk),
        .rst       (rst),
        .i_data    (data_in),
        .i_ld_r    (w_ld_r),
        .i_sel_sub (w_sel_sub),
        .i_ld_d    (w_ld_d),
        .i_clr_q   (w_clr_q),
        .i_inc_q   (w_inc_q),
        .o_ge      (w_ge),
        .o_dz      (w_dz),
        .o_r       (remainder),
        .o_q       (quotient)
    );

    always_comb begin
        w_next    = r_state;
        w_ld_r    = 1'b0;
        w_sel_sub = 1'b0;
        w_ld_d    = 1'b0;
        w_clr_q   = 1'b0;
        w_inc_q   = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (start) begin
                    w_ld_r  = 1'b1;
                    w_clr_q = 1'b1;
                    w_next  = c_st_loadd;
                end
            end
            c_st_loadd: begin
                w_ld_d = 1'b1;
                w_next = c_st_check;
            end
            c_st_check: begin
                w_next = w_dz ? c_st_done : c_st_iter;
            end
            c_st_iter: begin
                if (w_ge) begin
                    w_ld_r    = 1'b1;
                    w_sel_sub = 1'b1;
                    w_inc_q   = 1'b1;
                end else begin
                    w_next = c_st_done;
                end
            end
            c_st_done: begin
                w_next = c_st_idle;
            end
            default: begin
                w_next = c_st_idle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
            r_dz    <= 1'b0;
        end else begin
            r_state <= w_next;
            if ((r_state == c_st_idle) && start) begin
                r_dz <= 1'b0;
            end else if ((r_state == c_st_check) && w_dz) begin
                r_dz <= 1'b1;
            end
        end
    end

    assign busy        = (r_state != c_st_idle) && (r_state != c_st_done);
    assign done        = (r_state == c_st_done);
    assign div_by_zero = r_dz;

endmodule : div_repeated_sub
`default_nettype wire

// File: tb/tb_div_repeated_sub.sv
`default_nettype none
// ============================================================================
// Module      : tb_div_repeated_sub
// Description : Self-checking bench for div_repeated_sub with a result queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_div_repeated_sub;

    localparam int W = 16;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        int           lat;
        int           busy_cnt;
    } res_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] data_in = '0;
    logic         busy;
    logic         done;
    logic         div_by_zero;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;

    res_t sb[$];
    int   n_checks = 0;
    int   n_fail = 0;

    div_repeated_sub #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .data_in     (data_in),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .quotient    (quotient),
        .remainder   (remainder)
    );

    always #5 clk = ~clk;

    // Reference: done follows edge q+3 (edge 2 for a zero divisor); busy on every earlier edge from 1.
    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        res_t m;
        if (b == '0) begin
            m.q = '0; m.r = a; m.dz = 1'b1; m.lat = 2;
        end else begin
            m.q = a / b; m.r = a % b; m.dz = 1'b0; m.lat = int'(m.q) + 3;
        end
        m.busy_cnt = m.lat - 1;
        return m;
    endfunction

    task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b, input bit toggle, output res_t o);
        int e;
        bit seen;
        sb.push_back(model(a, b));
        @(negedge clk); start = 1'b1; data_in = a;
        @(negedge clk); start = 1'b0; data_in = b;
        e = 0; seen = 1'b0; o.busy_cnt = 0;
        while (!seen && e < 70000) begin
            @(negedge clk);
            e++;
            if (done) begin
                seen = 1'b1;
                if (busy) o.busy_cnt = o.busy_cnt + 1000000;
            end else begin
                if (busy) o.busy_cnt++;
                if (toggle) begin
                    start   = e[0];
                    data_in = W'($urandom);
                end
            end
        end
        start = 1'b0;
        o.lat = seen ? e : -1;
        o.q   = quotient;
        o.r   = remainder;
        o.dz  = div_by_zero;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
        n_checks++; if (div_by_zero !== 1'b0) begin n_fail++; $display("FAIL reset_dz: got %b expected 0", div_by_zero); end
        n_checks++; if (quotient !== '0) begin n_fail++; $display("FAIL reset_quot: got %0d expected 0", quotient); end
        n_checks++; if (remainder !== '0) begin n_fail++; $display("FAIL reset_rem: got %0d expected 0", remainder); end
        rst = 1'b0;
    endtask

    task automatic test_divide(input string name, input logic [W-1:0] a, input logic [W-1:0] b, input bit toggle);
        res_t o, ex;
        run_div(a, b, toggle, o);
        ex = sb.pop_front();
        n_checks++; if (o.q !== ex.q) begin n_fail++; $display("FAIL %s_quot: got %0d expected %0d", name, o.q, ex.q); end
        n_checks++; if (o.r !== ex.r) begin n_fail++; $display("FAIL %s_rem: got %0d expected %0d", name, o.r, ex.r); end
        n_checks++; if (o.dz !== ex.dz) begin n_fail++; $display("FAIL %s_dz: got %b expected %b", name, o.dz, ex.dz); end
        n_checks++; if (o.lat != ex.lat) begin n_fail++; $display("FAIL %s_latency: got %0d expected %0d", name, o.lat, ex.lat); end
        n_checks++; if (o.busy_cnt != ex.busy_cnt) begin n_fail++; $display("FAIL %s_busy_cycles: got %0d expected %0d", name, o.busy_cnt, ex.busy_cnt); end
    endtask

    task automatic test_div_by_zero();
        test_divide("div0", 16'd42, 16'd0, 1'b0);
        repeat (3) @(negedge clk);
        n_checks++; if (div_by_zero !== 1'b1) begin n_fail++; $display("FAIL div0_held: got %b expected 1", div_by_zero); end
        n_checks++; if (remainder !== 16'd42) begin n_fail++; $display("FAIL div0_rem_held: got %0d expected 42", remainder); end
        test_divide("after_div0", 16'd10, 16'd2, 1'b0);
    endtask

    task automatic test_reset_mid();
        int e;
        @(negedge clk); start = 1'b1; data_in = 16'd1000;
        @(negedge clk); start = 1'b0; data_in = 16'd1;
        e = 0;
        while (e < 49) begin @(negedge clk); e++; end
        // Subtractions occur on edges 3..49, so 47 have been counted.
        n_checks++; if (quotient !== 16'd47) begin n_fail++; $display("FAIL mid_quot: got %0d expected 47", quotient); end
        n_checks++; if (remainder !== 16'd953) begin n_fail++; $display("FAIL mid_rem: got %0d expected 953", remainder); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b expected 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL abort_done: got %b expected 0", done); end
        n_checks++; if (quotient !== '0) begin n_fail++; $display("FAIL abort_quot: got %0d expected 0", quotient); end
        n_checks++; if (remainder !== '0) begin n_fail++; $display("FAIL abort_rem: got %0d expected 0", remainder); end
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_idle: got busy=%b expected 0", busy); end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] as[5] = '{16'd7, 16'd65535, 16'd1, 16'd300, 16'd255};
        logic [W-1:0] bs[5] = '{16'd7, 16'd4096, 16'd65535, 16'd0, 16'd16};
        res_t obs[$];
        res_t o, ex;
        for (int i = 0; i < 5; i++) begin
            run_div(as[i], bs[i], 1'b0, o);
            obs.push_back(o);
        end
        for (int i = 0; i < 5; i++) begin
            o  = obs.pop_front();
            ex = sb.pop_front();
            n_checks++; if (o.q !== ex.q || o.r !== ex.r || o.dz !== ex.dz || o.lat != ex.lat)
                begin n_fail++; $display("FAIL b2b_%0d: got q=%0d r=%0d dz=%b lat=%0d expected q=%0d r=%0d dz=%b lat=%0d",
                    i, o.q, o.r, o.dz, o.lat, ex.q, ex.r, ex.dz, ex.lat); end
        end
    endtask

    initial begin
        test_reset();
        test_divide("basic_100_7", 16'd100, 16'd7, 1'b0);
        test_divide("small_5_9", 16'd5, 16'd9, 1'b0);
        test_divide("zero_0_3", 16'd0, 16'd3, 1'b0);
        test_divide("exact_9_3", 16'd9, 16'd3, 1'b0);
        test_div_by_zero();
        test_divide("max_65535_1", 16'd65535, 16'd1, 1'b0);
        test_reset_mid();
        test_divide("toggle_20_6", 16'd20, 16'd6, 1'b1);
        test_back_to_back();
        n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain: got %0d expected 0", sb.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_div_repeated_sub
`default_nettype wire

// File: doc/div_repeated_sub.md
Name: div_repeated_sub

Overview:
Sequential unsigned integer divider that computes quotient and remainder by repeated subtraction. It is the inverse companion of the repeated-addition multiplier and shares its single-bus loading style. The dividend and divisor arrive on one shared data_in bus in two consecutive cycles. A controller FSM then iterates subtract-and-count until the remainder is less than the divisor, and reports the result with a one-cycle done pulse.

Parameters:
WIDTH, 16, bit width of data_in, dividend, divisor, quotient and remainder

Ports:
clk  in  1  system clock; all state updates on posedge
rst  in  1  synchronous active-high reset
start  in  1  pulse in IDLE; data_in carries the dividend in that cycle
data_in  in  WIDTH  shared load bus; dividend in the start cycle, divisor in the next cycle
busy  out  1  high from the cycle after start is accepted until done
done  out  1  one-cycle pulse; quotient, remainder and div_by_zero are valid
div_by_zero  out  1  set with done when divisor==0; held until next accepted start
quotient  out  WIDTH  result; held stable after done until next accepted start
remainder  out  WIDTH  result; held stable after done until next accepted start

Behaviour:
- Reset (rst=1 at posedge):
  - state goes to IDLE.
  - R, D, Q, busy, done and div_by_zero are all cleared to 0.
  - Reset overrides every other input, including mid-operation; any in-flight division is abandoned.
- Datapath registers:
  - R: remainder register; loads data_in, or loads R-D.
  - D: divisor register; loads data_in.
  - Q: quotient counter; clears to 0, or increments by 1.
  - Comparator: ge = (R >= D), unsigned WIDTH-bit compare.
  - Zero detect: dz = (D == 0).
  - Subtractor is WIDTH-bit with no borrow out. It is only used when ge=1, so it cannot underflow.
- States: IDLE, LOADD, CHECK, ITER, DONE.
- IDLE:
  - If start=1: R<=data_in, Q<=0, div_by_zero<=0, next state LOADD.
  - start=0 keeps the state; start asserted in any non-IDLE state is ignored.
- LOADD: D<=data_in; next state CHECK. start is ignored here.
- CHECK:
  - If dz: div_by_zero<=1, next state DONE (Q=0, R=dividend).
  - Otherwise next state ITER.
- ITER:
  - If ge: R<=R-D, Q<=Q+1, stay in ITER.
  - Otherwise next state DONE.
- DONE: done=1 for exactly this one cycle; next state IDLE.
- busy = (state != IDLE) && (state != DONE). busy and done are never high together.
- Latency, counting the posedge that samples start as edge 0:
  - Normal case: done is high in the cycle after edge q+3, where q is the final quotient. Worst case is dividend=2^WIDTH-1, divisor=1: 65538 edges.
  - Divide by zero: done is high after edge 2.
- Output timing: quotient and remainder reflect Q and R directly. They are intermediate values while busy, and final from the done cycle onward. They stay held through IDLE until the next accepted start.
- Back-to-back operation: start is accepted in the IDLE cycle immediately following DONE.

Decomposition:
- Shared package (div_pkg):
  - WIDTH default.
  - FSM state encoding constants, 3-bit: IDLE=0, LOADD=1, CHECK=2, ITER=3, DONE=4.
- Sub-module div_datapath: R, D and Q registers, subtractor, comparator and zero detect. Control inputs are ldR, selSub, ldD, clrQ, incQ; status outputs are ge and dz.
- The top level div_repeated_sub holds the FSM and output logic and instantiates div_datapath.

Test Plan:
1. start with data_in=100, next cycle data_in=7 -> quotient=14, remainder=2, div_by_zero=0; done high after edge 17; busy high edges 1..16.
2. 5 / 9 -> quotient=0, remainder=5; done after edge 3.
3. 0 / 3 -> quotient=0, remainder=0, done after edge 3. 9 / 3 -> quotient=3, remainder=0, done after edge 6 (exact-division boundary).
4. 42 / 0 -> div_by_zero=1, quotient=0, remainder=42, done after edge 2. Then 10 / 2 -> div_by_zero cleared, quotient=5, remainder=0.
5. 65535 / 1 -> quotient=65535, remainder=0, done after edge 65538. Q does not wrap.
6. Start 1000 / 1, assert rst for one cycle at edge 50 -> next cycle state is IDLE and all outputs are 0. Toggling start during busy has no effect; a new 20 / 6 then gives quotient=3, remainder=2.
